// File: rtl/serial_sample_receiver.sv
// ---------------------------------------------------------------------------
// serial_sample_receiver
//   Deserialises a framed, idle-high serial stream back into parallel sample
//   words. Frame format: start bit (low), DATA_BITS data bits LSB first,
//   optional even parity bit, stop bit (high). Each bit is sampled at mid-bit.
//   Good words go into a small first-word-fall-through FIFO. Framing, parity
//   and overflow events are reported as one-cycle pulses.
//
// Ports
//   sensor_clk    in   sole clock, all logic on posedge
//   sensor_rst_n  in   synchronous active-low reset
//   serial_in     in   framed serial stream (asynchronous to sensor_clk)
//   rx_enable     in   1 = new frames may start (checked only in IDLE)
//   sample_data   out  FIFO head word (0 while the FIFO is empty)
//   sample_valid  out  FIFO non-empty
//   sample_ready  in   consumer takes the head word when valid && ready
//   fifo_count    out  words held (0..FIFO_DEPTH)
//   rx_busy       out  receiver is inside a frame (state != IDLE)
//   frame_err     out  1-cycle pulse: stop bit sampled low
//   parity_err    out  1-cycle pulse: parity mismatch
//   overflow      out  1-cycle pulse: good word dropped because FIFO full
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a falling edge on the synchronised line
// START  | timing half a bit, then re-checking the start bit
// DATA   | sampling DATA_BITS data bits, LSB first
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit, then push / report an error
// ---------------------------------------------------------------------------
module serial_sample_receiver #(
   parameter int DATA_BITS    = 16,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          sensor_clk,
   input  logic                          sensor_rst_n,
   input  logic                          serial_in,
   input  logic                          rx_enable,
   output logic [DATA_BITS-1:0]          sample_data,
   output logic                          sample_valid,
   input  logic                          sample_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          rx_busy,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overflow
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   // Bit timers count down and act on terminal count zero.
   localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t               state, state_d;
   logic [CW-1:0]        cnt, cnt_d;
   logic [BW-1:0]        bit_cnt, bit_d;
   logic [DATA_BITS-1:0] data, data_d;
   logic                 par_ok, par_ok_d;
   logic                 push, fe_d, pe_d;

   logic                 sync1, s_in, s_prev;
   logic [1:0]           fill;
   logic                 armed;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic                 pop, accept;

   // Input synchroniser and arming. The reset value of the synchroniser is
   // not a real observation of the line, so arming only trusts s_in once
   // both stages have been refilled from serial_in. A line held low through
   // reset therefore has to go high before any frame can start.
   always_ff @(posedge sensor_clk) begin
      if (!sensor_rst_n) begin
         sync1  <= 1'b1;
         s_in   <= 1'b1;
         s_prev <= 1'b1;
         fill   <= 2'b00;
         armed  <= 1'b0;
      end else begin
         sync1  <= serial_in;
         s_in   <= sync1;
         s_prev <= s_in;
         fill   <= {fill[0], 1'b1};
         if (s_in && fill[1])
            armed <= 1'b1;
      end
   end

   always_ff @(posedge sensor_clk) begin
      if (!sensor_rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         data    <= '0;
         par_ok  <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_cnt <= bit_d;
         data    <= data_d;
         par_ok  <= par_ok_d;
      end
   end

   always_comb begin
      state_d  = state;
      cnt_d    = (cnt != '0) ? cnt - 1'b1 : '0;
      bit_d    = bit_cnt;
      data_d   = data;
      par_ok_d = par_ok;
      push     = 1'b0;
      fe_d     = 1'b0;
      pe_d     = 1'b0;
      case (state)
         IDLE: begin
            if (s_prev && !s_in && rx_enable && armed) begin
               state_d = START;
               cnt_d   = HALF_TC;
            end
         end
         START: begin
            if (cnt == '0) begin
               if (s_in) begin
                  state_d = IDLE;
               end else begin
                  state_d  = DATA;
                  cnt_d    = BIT_TC;
                  bit_d    = '0;
                  par_ok_d = 1'b1;
               end
            end
         end
         DATA: begin
            if (cnt == '0) begin
               data_d[bit_cnt] = s_in;
               cnt_d           = BIT_TC;
               if (bit_cnt == LAST_BIT)
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               else
                  bit_d = bit_cnt + 1'b1;
            end
         end
         PARITY: begin
            if (cnt == '0) begin
               par_ok_d = ~(^data ^ s_in);
               cnt_d    = BIT_TC;
               state_d  = STOP;
            end
         end
         STOP: begin
            if (cnt == '0) begin
               state_d = IDLE;
               if (!s_in)
                  fe_d = 1'b1;
               else if (!par_ok)
                  pe_d = 1'b1;
               else
                  push = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A pop in the same cycle frees a slot, so a push into a full FIFO is
   // still accepted when the consumer is taking the head word.
   assign sample_valid = (fifo_count != '0);
   assign pop          = sample_valid && sample_ready;
   assign accept       = push && ((fifo_count != FULL_CNT) || pop);
   assign sample_data  = sample_valid ? mem[rd_ptr] : '0;
   assign rx_busy      = (state != IDLE);

   always_ff @(posedge sensor_clk) begin
      if (!sensor_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         frame_err  <= fe_d;
         parity_err <= pe_d;
         overflow   <= push && !accept;
      end
   end

endmodule
